// File: rtl/madd_msub_unit_if.sv
// Operand/result bundle between the EX stage and the multiply-accumulate unit.
// The slave side is the arithmetic unit; the master side is the pipeline stage.
interface madd_msub_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        hold;
  logic        flush;
  logic        stallreq;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;
  logic [1:0]  cnt_o;

  modport slave (
    input  start, op, reg1_i, reg2_i, hi_i, lo_i, hold, flush,
    output stallreq, hi_o, lo_o, whilo_o, cnt_o
  );

  modport master (
    output start, op, reg1_i, reg2_i, hi_i, lo_i, hold, flush,
    input  stallreq, hi_o, lo_o, whilo_o, cnt_o
  );
endinterface

// File: rtl/madd_msub_unit.sv
// Two-cycle MADD/MADDU/MSUB/MSUBU unit: multiply in IDLE->MUL, accumulate
// against forwarded HI/LO in MUL->ACC, and pulse the HI/LO write enable in ACC.
module madd_msub_unit (
  input  logic                  clk,
  input  logic                  rst,
  madd_msub_unit_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    ACC  = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] product_q, product_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] opA, opB, productNow, hiloIn;

  // Odd op codes are the unsigned variants, so op[0] selects zero-extension.
  assign opA        = bus.op[0] ? {32'b0, bus.reg1_i} : {{32{bus.reg1_i[31]}}, bus.reg1_i};
  assign opB        = bus.op[0] ? {32'b0, bus.reg2_i} : {{32{bus.reg2_i[31]}}, bus.reg2_i};
  assign productNow = opA * opB;
  assign hiloIn     = {bus.hi_i, bus.lo_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      product_q <= 64'b0;
      hi_q      <= 32'b0;
      lo_q      <= 32'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      product_q <= product_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Flush beats hold, and hold beats normal sequencing.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    product_d = product_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (bus.flush) begin
      state_d   = IDLE;
      product_d = 64'b0;
    end else if (!bus.hold) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_d      = bus.op;
            product_d = productNow;
            state_d   = MUL;
          end
        end
        MUL: begin
          if (op_q[1])
            {hi_d, lo_d} = hiloIn - product_q;
          else
            {hi_d, lo_d} = hiloIn + product_q;
          state_d = ACC;
        end
        ACC:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.stallreq = ((state_q == IDLE) && bus.start) || (state_q == MUL);
  assign bus.whilo_o  = (state_q == ACC);
  assign bus.cnt_o    = state_q;
  assign bus.hi_o     = hi_q;
  assign bus.lo_o     = lo_q;

endmodule

// File: doc/madd_msub_unit.md
MADD_MSUB_UNIT -- requirements
Module: madd_msub_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1, EX-stage MADD/MADDU/MSUB/MSUBU decoded this cycle.
REQ-004 SHALL have port op, input, 2, 00 MADD, 01 MADDU, 10 MSUB, 11 MSUBU.
REQ-005 SHALL have port reg1_i, input, 32, rs operand.
REQ-006 SHALL have port reg2_i, input, 32, rt operand.
REQ-007 SHALL have port hi_i, input, 32, current forwarded HI value.
REQ-008 SHALL have port lo_i, input, 32, current forwarded LO value.
REQ-009 SHALL have port hold, input, 1, EX stage stalled by a downstream stage (stall[3]=1 and stall[4]=1); freezes unit.
REQ-010 SHALL have port flush, input, 1, abort the in-flight operation.
REQ-011 SHALL have port stallreq, output, 1, pipeline stall request to control.
REQ-012 SHALL have port hi_o, output, 32, accumulated result upper word.
REQ-013 SHALL have port lo_o, output, 32, accumulated result lower word.
REQ-014 SHALL have port whilo_o, output, 1, HI/LO write enable, one-cycle pulse.
REQ-015 SHALL have port cnt_o, output, 2, phase: 00 IDLE, 01 MUL, 10 ACC.

Function
REQ-016 SHALL implement states IDLE, MUL, ACC; cnt_o encodes state directly; 11 never produced.
REQ-017 SHALL, in IDLE with start=1 and hold=0 and flush=0: register op and 64-bit product; next state MUL.
REQ-018 SHALL form the product signed (sign-extended operands) for op 00/10, unsigned (zero-extended) for op 01/11.
REQ-019 SHALL, in MUL with hold=0: sample {hi_i,lo_i}, register {hi_o,lo_o} = {hi_i,lo_i} + product (op 00/01) or {hi_i,lo_i} - product (op 10/11), modulo 2^64; next state ACC.
REQ-020 SHALL, in ACC: drive whilo_o=1 for exactly that cycle; next state IDLE unconditionally; start seen in ACC is ignored.
REQ-021 SHALL drive stallreq combinationally = (IDLE and start) or MUL; stallreq=0 in ACC.
REQ-022 SHALL, with hold=1 in any state, keep state, product, hi_o, lo_o unchanged; whilo_o stays high if in ACC.
REQ-023 SHALL, with flush=1, go to IDLE next edge, discard product, never pulse whilo_o for the flushed operation; flush overrides hold and start.
REQ-024 SHALL hold hi_o/lo_o at their last computed value in IDLE; whilo_o=0 in IDLE and MUL.
REQ-025 SHALL have latency: start accepted at edge N, ACC (whilo_o=1) during cycle N+2 absent hold.

Reset
REQ-026 SHALL, on rst=1, immediately (no clock) force IDLE, product=0, hi_o=0, lo_o=0, whilo_o=0, cnt_o=00; stallreq=start while rst held.
REQ-027 SHALL, on reset mid-MUL or mid-ACC, drop the operation with no whilo_o pulse after reset release.

Verification
REQ-028 SHALL test MADD: hi_i=0, lo_i=5, rs=3, rt=4 -> stallreq high 2 cycles, ACC cycle {hi_o,lo_o}=0x00000000_00000011, whilo_o one pulse.
REQ-029 SHALL test signedness: hilo=0, rs=0xFFFFFFFF, rt=2 -> MADD 0xFFFFFFFF_FFFFFFFE; MADDU 0x00000001_FFFFFFFE.
REQ-030 SHALL test MSUB wrap: hilo=0, rs=1, rt=1 -> 0xFFFFFFFF_FFFFFFFF; MSUBU hilo=0x00000000_00000002, rs=1, rt=1 -> 0x00000000_00000001.
REQ-031 SHALL test hold=1 for 3 cycles in MUL -> cnt_o stays 01, stallreq stays 1, result identical to REQ-028 case, pulse delayed 3 cycles.
REQ-032 SHALL test rst asserted mid-MUL -> outputs zero before next edge, cnt_o=00, no whilo_o pulse afterwards.
REQ-033 SHALL test flush in MUL with start=1 -> IDLE next cycle, hi_o/lo_o unchanged, no whilo_o pulse.
